noc_switch_allocator: RTL
=========================

Name: noc_switch_allocator

Overview:
- Per-router output-port allocator for the 5-port XY mesh router: L, E, W, S, N.
- Takes each input port's one-hot route request from route computation and arbitrates every output port round-robin among the requesting inputs.
- Holds a wormhole lock on each output from header flit to tail flit.
- Drives the crossbar select lines and the per-input transfer grant.

Parameters:
- NUM_PORTS, 5, number of router ports; index order 0=L, 1=E, 2=W, 3=S, 4=N, matching the route-compute one-hot enables e1..e5.
- SEL_W, 3, width of one crossbar select field.
- CNT_W, 16, width of each flit counter (optional feature only).

Ports:
- clk  in  1  router clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  NUM_PORTS  input i holds a flit.
- in_flit_type  in  2*NUM_PORTS  flit type of input i at [2i+1:2i]: 2'b10 header, 2'b00 body, 2'b01 tail, 2'b11 single-flit packet.
- in_req  in  NUM_PORTS*NUM_PORTS  route request of input i at [5i+4:5i], one bit per output in port order.
- out_ready  in  NUM_PORTS  downstream of output o can accept a flit this cycle.
- in_grant  out  NUM_PORTS  flit of input i transfers this cycle (combinational).
- out_valid  out  NUM_PORTS  output o carries a flit this cycle.
- xbar_sel  out  SEL_W*NUM_PORTS  input index driving output o; 3'd7 when idle.
- out_locked  out  NUM_PORTS  registered lock state of output o.
- flit_cnt  out  CNT_W*NUM_PORTS  per-output transferred-flit count (present only with the optional feature).

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-low reset rst_n. Reset is sampled on the clk edge only.
- Request decode:
  - Effective request of input i to output o = in_valid[i] & req bit o.
  - A non-one-hot in_req uses the lowest set bit only.
  - An all-zero in_req requests nothing.
- Per-output FSM, two states:
  - IDLE:
    - Eligible inputs are those requesting o with type 2'b10 or 2'b11.
    - Winner = first eligible input scanning from ptr[o] upward, wrapping mod 5.
    - If out_ready[o]=1: grant the winner that cycle.
    - Type 2'b10 granted → LOCKED, owner=winner.
    - Type 2'b11 granted → stay IDLE, ptr[o]=winner+1 mod 5.
    - Body or tail flits are never granted in IDLE.
  - LOCKED:
    - Only the owner is eligible, and only with type 2'b00 or 2'b01.
    - Grant when out_ready[o]=1.
    - Tail granted → IDLE, ptr[o]=owner+1 mod 5.
    - A header from the owner, or any flit from another input, is not granted.
- Latency:
  - Grant, xbar_sel and out_valid are combinational, same cycle as the request.
  - FSM, owner and ptr update on the next clk edge.
- Grant outputs:
  - in_grant[i] = OR over all outputs of grant(o,i).
  - out_valid[o] = a grant exists on o.
  - xbar_sel[o] = winner index when out_valid[o]=1; else owner when LOCKED; else 3'd7.
- Backpressure: out_ready[o]=0 → no grant on o; state, owner and ptr unchanged.
- Simultaneous events: tail transfer and a waiting header on the same output → the header is considered next cycle at the earliest.
- Reset values:
  - All FSMs IDLE, ptr=0, out_locked=0.
  - While rst_n=0: in_grant=0, out_valid=0, xbar_sel all 3'd7.
- Reset mid-packet: all locks dropped; the remainder of that packet is discarded upstream (not granted).

Optional Feature:
- Macro: SA_FLIT_CNT_EN.
- With the macro:
  - flit_cnt port present; per-output CNT_W counter increments on each out_valid.
  - Wraps at 2^CNT_W-1 → 0.
  - Cleared by reset.
- Without the macro: flit_cnt port and the counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package noc_pkg:
  - port index constants L=0, E=1, W=2, S=3, N=4; NUM_PORTS.
  - flit type codes HDR/BODY/TAIL/SINGLE; SEL_IDLE=3'd7.
- Sub-module noc_rr_arbiter: 5-way round-robin arbiter with request vector, pointer and one-hot grant. Instantiate once per output.

Test Plan:
- Reset: rst_n=0 for 3 cycles with all in_valid=1 and headers → in_grant=0, xbar_sel=all 3'd7, out_locked=0.
- Single packet: input E sends HDR,BODY,TAIL to L (in_req bit0), out_ready=1 → in_grant[1]=1 for three cycles, xbar_sel[L]=1, out_locked[L]=1 on cycles 2-3, back to 0 after the tail.
- Contention: inputs 0, 2 and 4 each send a 2-flit packet (HDR,TAIL) to S simultaneously → service order 0, 2, 4 over cycles 1-2, 3-4 and 5-6.
- Backpressure: out_ready[S]=0 for 2 cycles mid-packet → no grant, out_locked[S] stays 1, owner unchanged; flits resume when out_ready returns.
- Interleave blocked: E locked on owner 0; input 3 sends BODY to E → never granted, xbar_sel[E]=0.
- Single-flit: input 1 sends 2'b11 to N, then input 2 a header to N next cycle → both granted in consecutive cycles, out_locked[N]=0 after the first.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the 5-port XY mesh router switch allocator.
// Contents: port index constants (L/E/W/S/N), flit type codes, the idle
// crossbar select value and small flit-type classification helpers.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;

  // Port index order matches the route-compute one-hot enables e1..e5.
  localparam int unsigned L = 0;
  localparam int unsigned E = 1;
  localparam int unsigned W = 2;
  localparam int unsigned S = 3;
  localparam int unsigned N = 4;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    TAIL   = 2'b01,
    HDR    = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  localparam logic [2:0] SEL_IDLE = 3'd7;

  // Flits that may acquire an idle output.
  function automatic logic opens_packet(input logic [1:0] t);
    return (t == HDR) || (t == SINGLE);
  endfunction

  // Flits that may only follow a header through a locked output.
  function automatic logic continues_packet(input logic [1:0] t);
    return (t == BODY) || (t == TAIL);
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - index of the highest-priority requester this cycle
//   gnt  - one-hot grant: first set req bit scanning from ptr upward, wrapping
module noc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned N_REQ = NUM_PORTS,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  int unsigned        pos;
  logic               found;
  logic [N_REQ-1:0]   mask;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = 0;
    mask  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos  = (32'(ptr) + k) % N_REQ;
      mask = N_REQ'(1) << pos;
      if (!found && |(req & mask)) begin
        gnt   = mask;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Per-router output-port allocator for the 5-port XY mesh router.
// Each output runs a two-state IDLE/LOCKED machine: in IDLE it arbitrates
// round-robin among header/single-flit requesters, in LOCKED it passes only
// the owner's body/tail flits (wormhole lock from header to tail).
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   in_valid      - input i holds a flit
//   in_flit_type  - 2-bit flit type of input i at [2i+1:2i]
//   in_req        - route request of input i at [5i+4:5i] (lowest set bit used)
//   out_ready     - downstream of output o can accept a flit
//   in_grant      - flit of input i transfers this cycle (combinational)
//   out_valid     - output o carries a flit this cycle (combinational)
//   xbar_sel      - input index driving output o, SEL_IDLE when idle
//   out_locked    - registered lock state of output o
//   flit_cnt      - per-output transferred-flit counters (SA_FLIT_CNT_EN only)
// Optional feature macro: SA_FLIT_CNT_EN.
module noc_switch_allocator
  import noc_pkg::*;
#(
  parameter int unsigned NUM_PORTS = noc_pkg::NUM_PORTS,
  parameter int unsigned SEL_W     = 3
`ifdef SA_FLIT_CNT_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [2*NUM_PORTS-1:0]         in_flit_type,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] in_req,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS-1:0]           in_grant,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [SEL_W*NUM_PORTS-1:0]     xbar_sel,
  output logic [NUM_PORTS-1:0]           out_locked
`ifdef SA_FLIT_CNT_EN
  ,
  output logic [CNT_W*NUM_PORTS-1:0]     flit_cnt
`endif
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  function automatic logic [SEL_W-1:0] oh_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (|(oh & (NUM_PORTS'(1) << k))) idx = SEL_W'(k);
    end
    return idx;
  endfunction

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  logic [1:0]           ftype      [NUM_PORTS];
  logic [NUM_PORTS-1:0] eff_req    [NUM_PORTS];  // [input][output]
  logic [NUM_PORTS-1:0] gnt_by_out [NUM_PORTS];  // [output][input]

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    logic [NUM_PORTS-1:0] raw;
    logic [NUM_PORTS-1:0] gnt_col;

    assign raw      = in_req[i*NUM_PORTS +: NUM_PORTS];
    assign ftype[i] = in_flit_type[2*i +: 2];
    // raw & -raw isolates the lowest set bit, so multi-hot requests collapse.
    assign eff_req[i] = (raw & (~raw + NUM_PORTS'(1))) & {NUM_PORTS{in_valid[i]}};

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_col
      assign gnt_col[o] = gnt_by_out[o][i];
    end
    assign in_grant[i] = |gnt_col;
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [0:0]           state_q, state_d;
    logic [SEL_W-1:0]     owner_q, owner_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     win_idx;
    logic [1:0]           win_type;
    logic [NUM_PORTS-1:0] head_req, cont_req, arb_gnt, gnt;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_elig
      assign head_req[i] = eff_req[i][o] && opens_packet(ftype[i]);
      assign cont_req[i] = eff_req[i][o] && continues_packet(ftype[i]);
    end

    noc_rr_arbiter #(
      .N_REQ (NUM_PORTS),
      .IDX_W (SEL_W)
    ) u_arb (
      .req (head_req),
      .ptr (ptr_q),
      .gnt (arb_gnt)
    );

    // Grants are masked while in reset so nothing transfers before the
    // registered state has been cleared.
    always_comb begin
      gnt = '0;
      if (rst_n && out_ready[o]) begin
        if (state_q == ST_IDLE) gnt = arb_gnt;
        else                    gnt = cont_req & (NUM_PORTS'(1) << owner_q);
      end
    end

    assign win_idx  = oh_to_idx(gnt);
    assign win_type = ftype[win_idx];

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      if (|gnt) begin
        if (state_q == ST_IDLE) begin
          if (win_type == HDR) begin
            state_d = ST_LOCKED;
            owner_d = win_idx;
          end else begin
            ptr_d = wrap_inc(win_idx);
          end
        end else if (win_type == TAIL) begin
          // Returning to IDLE only takes effect next cycle, so a header
          // waiting alongside the tail is considered no earlier than that.
          state_d = ST_IDLE;
          ptr_d   = wrap_inc(owner_q);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
      end
    end

    assign gnt_by_out[o] = gnt;
    assign out_valid[o]  = |gnt;
    assign out_locked[o] = (state_q == ST_LOCKED);
    assign xbar_sel[o*SEL_W +: SEL_W] =
      !rst_n                  ? SEL_W'(SEL_IDLE) :
      (|gnt)                  ? win_idx          :
      (state_q == ST_LOCKED)  ? owner_q          : SEL_W'(SEL_IDLE);

`ifdef SA_FLIT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + CNT_W'(|gnt);

    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign flit_cnt[o*CNT_W +: CNT_W] = cnt_q;
`endif
  end

endmodule
